writeback_arbiter: RTL and testbench

- Write-back stage that drives the register-file write port of the decode stage: op_RegWrite, op_write_reg_addr and op_write_data.
- Registers the memory-stage result and applies the MemtoReg mux.
- Also accepts results from a long-latency unit (mult/div) over a valid/ready handshake, queuing them in a small FIFO.
- Exports a pending-write mask for the hazard detection unit.

---
 rtl/writeback_arbiter_pkg.sv | 17 +
 rtl/writeback_arbiter_if.sv | 36 +++
 rtl/writeback_arbiter_fifo.sv | 63 ++++++
 rtl/writeback_arbiter.sv | 107 ++++++++++
 tb/tb_writeback_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the write-back arbiter: register-file geometry and the queued long-latency entry.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Write-back port bundle: memory-stage result, long-latency valid/ready result, register-file write and hazard mask.
interface writeback_arbiter_if #(parameter int LL_DEPTH = 4);
  import wb_pkg::*;

  localparam int CNT_W = $clog2(LL_DEPTH) + 1;

  logic                  ip_RegWrite;
  logic                  ip_MemtoReg;
  logic [REG_ADDR_W-1:0] ip_dest_reg;
  logic [DATA_W-1:0]     ip_alu_result;
  logic [DATA_W-1:0]     ip_mem_read_data;
  logic                  ip_ll_valid;
  logic [REG_ADDR_W-1:0] ip_ll_dest_reg;
  logic [DATA_W-1:0]     ip_ll_data;
  logic                  op_ll_ready;
  logic                  op_RegWrite;
  logic [REG_ADDR_W-1:0] op_write_reg_addr;
  logic [DATA_W-1:0]     op_write_data;
  logic [NUM_REGS-1:0]   op_pending_mask;
  logic [CNT_W-1:0]      op_ll_count;

  modport slave (
    input  ip_RegWrite, ip_MemtoReg, ip_dest_reg, ip_alu_result, ip_mem_read_data,
           ip_ll_valid, ip_ll_dest_reg, ip_ll_data,
    output op_ll_ready, op_RegWrite, op_write_reg_addr, op_write_data,
           op_pending_mask, op_ll_count
  );

  modport master (
    output ip_RegWrite, ip_MemtoReg, ip_dest_reg, ip_alu_result, ip_mem_read_data,
           ip_ll_valid, ip_ll_dest_reg, ip_ll_data,
    input  op_ll_ready, op_RegWrite, op_write_reg_addr, op_write_data,
           op_pending_mask, op_ll_count
  );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Circular FIFO of long-latency results; exposes per-slot valid/dest so the owner can build a pending mask.
// Push is ignored when full, pop when empty; count separates full from empty since pointers wrap.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                push,
  input  wb_entry_t                           push_entry,
  input  logic                                pop,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(DEPTH):0]              count,
  output wb_entry_t                           head,
  output logic [DEPTH-1:0]                    ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_dest
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; slot validity comes solely from the pointers and count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] offs;
    assign offs         = PTR_W'(i) - rd_ptr;
    assign ent_valid[i] = ({1'b0, offs} < count);
    assign ent_dest[i]  = mem[i].dest;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back stage: pipeline result (1 cycle, always wins) or queued long-latency result onto the register-file port.
// Long-latency input stalls via op_ll_ready when the FIFO is full; WB_LL_BYPASS_EN lets an idle-stage result skip the FIFO.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int LL_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  writeback_arbiter_if.slave   wb
);

  localparam int CNT_W = $clog2(LL_DEPTH) + 1;

  logic                             pipe_wr;
  logic                             ll_take;
  logic                             ll_bypass;
  logic                             fifo_push;
  logic                             fifo_pop;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [CNT_W-1:0]                 fifo_count;
  wb_entry_t                        fifo_head;
  wb_entry_t                        ll_entry;
  logic [LL_DEPTH-1:0]              ent_valid;
  logic [LL_DEPTH-1:0][REG_ADDR_W-1:0] ent_dest;

  logic                  we_q,   we_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [NUM_REGS-1:0]   pending;

  assign pipe_wr        = wb.ip_RegWrite && (wb.ip_dest_reg != '0);
  assign wb.op_ll_ready = !fifo_full && !reset;
  // r0 results complete the handshake but never reach the queue or the port.
  assign ll_take        = wb.ip_ll_valid && wb.op_ll_ready && (wb.ip_ll_dest_reg != '0);
  assign ll_entry       = '{dest: wb.ip_ll_dest_reg, data: wb.ip_ll_data};

`ifdef WB_LL_BYPASS_EN
  assign ll_bypass = !pipe_wr && fifo_empty && ll_take;
`else
  assign ll_bypass = 1'b0;
`endif

  assign fifo_push = ll_take && !ll_bypass;
  assign fifo_pop  = !pipe_wr && !fifo_empty;

  wb_fifo #(.DEPTH(LL_DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (ll_entry),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head       (fifo_head),
    .ent_valid  (ent_valid),
    .ent_dest   (ent_dest)
  );

  always_comb begin
    we_d   = 1'b0;
    addr_d = '0;
    data_d = '0;
    if (pipe_wr) begin
      we_d   = 1'b1;
      addr_d = wb.ip_dest_reg;
      data_d = wb.ip_MemtoReg ? wb.ip_mem_read_data : wb.ip_alu_result;
    end else if (fifo_pop) begin
      we_d   = 1'b1;
      addr_d = fifo_head.dest;
      data_d = fifo_head.data;
    end else if (ll_bypass) begin
      we_d   = 1'b1;
      addr_d = ll_entry.dest;
      data_d = ll_entry.data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Derived from registered FIFO state, so a popped entry's bit drops at the popping edge.
  always_comb begin
    pending = '0;
    for (int i = 0; i < LL_DEPTH; i++) begin
      if (ent_valid[i]) pending = pending | reg_onehot(ent_dest[i]);
    end
  end

  assign wb.op_RegWrite       = we_q;
  assign wb.op_write_reg_addr = addr_q;
  assign wb.op_write_data     = data_q;
  assign wb.op_pending_mask   = pending;
  assign wb.op_ll_count       = fifo_count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: queue-based reference model predicts each register-file write.
module tb_writeback_arbiter;

  localparam int LLD = 4;
`ifdef WB_LL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    int          cnt;
    logic [31:0] mask;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   fails = 0;

  ent_t mq[$];
  exp_t sb[$];

  writeback_arbiter_if #(.LL_DEPTH(LLD)) wb();

  writeback_arbiter #(.LL_DEPTH(LLD)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i].dest] = 1'b1;
    return m;
  endfunction

  // Drive one cycle of stimulus at the negedge and predict what the next edge must produce.
  task automatic step(input logic rw, input logic mtr, input logic [4:0] d,
                      input logic [31:0] alu, input logic [31:0] mem,
                      input logic llv, input logic [4:0] lld, input logic [31:0] lldat);
    exp_t e;
    ent_t h;
    bit   pw, rdy, take, byp;
    wb.ip_RegWrite      = rw;
    wb.ip_MemtoReg      = mtr;
    wb.ip_dest_reg      = d;
    wb.ip_alu_result    = alu;
    wb.ip_mem_read_data = mem;
    wb.ip_ll_valid      = llv;
    wb.ip_ll_dest_reg   = lld;
    wb.ip_ll_data       = lldat;
    #1;
    pw   = rw && (d != 0);
    rdy  = (mq.size() < LLD);
    check("ll_ready", 32'(wb.op_ll_ready), 32'(rdy));
    take = llv && rdy && (lld != 0);
    byp  = 1'b0;
    e.we = 1'b0; e.addr = '0; e.data = '0;
    if (pw) begin
      e.we = 1'b1; e.addr = d; e.data = mtr ? mem : alu;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      e.we = 1'b1; e.addr = h.dest; e.data = h.data;
    end else if (BYPASS && take) begin
      e.we = 1'b1; e.addr = lld; e.data = lldat; byp = 1'b1;
    end
    if (take && !byp) begin
      h.dest = lld; h.data = lldat;
      mq.push_back(h);
    end
    e.cnt  = mq.size();
    e.mask = model_mask();
    sb.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_regwrite", 32'(wb.op_RegWrite), 32'd0);
    check("rst_addr",     32'(wb.op_write_reg_addr), 32'd0);
    check("rst_data",     wb.op_write_data, 32'd0);
    check("rst_count",    32'(wb.op_ll_count), 32'd0);
    check("rst_mask",     wb.op_pending_mask, 32'd0);
    check("rst_ready",    32'(wb.op_ll_ready), 32'd0);
  endtask

  // Monitor: every edge consumes one prediction and compares the whole output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("regwrite", 32'(wb.op_RegWrite), 32'(e.we));
        check("addr",     32'(wb.op_write_reg_addr), 32'(e.addr));
        check("data",     wb.op_write_data, e.data);
        check("count",    32'(wb.op_ll_count), 32'(e.cnt));
        check("mask",     wb.op_pending_mask, e.mask);
      end
    end
  end

  initial begin
    int bias;
    wb.ip_RegWrite = 0; wb.ip_MemtoReg = 0; wb.ip_dest_reg = 0;
    wb.ip_alu_result = 0; wb.ip_mem_read_data = 0;
    wb.ip_ll_valid = 0; wb.ip_ll_dest_reg = 0; wb.ip_ll_data = 0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Pipeline mux and r0 suppression
    step(1, 0, 8, 32'h1234, 32'hBEEF, 0, 0, 0);
    step(1, 1, 8, 32'h1234, 32'hBEEF, 0, 0, 0);
    step(1, 0, 0, 32'h1234, 32'hBEEF, 0, 0, 0);

    // Pipeline priority over a queued result
    step(1, 0, 3, 32'h3333, 0, 1, 5, 32'hAAAA);
    step(1, 0, 3, 32'h3334, 0, 0, 0, 0);
    step(1, 0, 3, 32'h3335, 0, 0, 0, 0);
    idle(2);

    // Fill past capacity while pipeline busy, then drain in order
    for (int i = 1; i <= 5; i++) step(1, 0, 20, 32'(i), 0, 1, 5'(i), 32'(i * 16));
    idle(5);

    // Duplicate destination
    step(1, 0, 11, 0, 0, 1, 7, 32'h1);
    step(1, 0, 11, 0, 0, 1, 7, 32'h2);
    idle(3);

    // Empty FIFO, idle stage: bypass or single-cycle pass through the queue
    step(0, 0, 0, 0, 0, 1, 9, 32'h55);
    idle(2);

    // r0 long-latency result is discarded
    step(0, 0, 0, 0, 0, 1, 0, 32'hDEAD);
    idle(1);

    // Reset with two entries queued
    step(1, 0, 12, 0, 0, 1, 1, 32'h11);
    step(1, 0, 12, 0, 0, 1, 2, 32'h22);
    wb.ip_ll_valid = 0; wb.ip_RegWrite = 0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    mq.delete();
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(wb.op_ll_ready), 32'd1);
    @(negedge clock);

    // Randomised traffic with phases of varying pipeline load
    bias = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) bias = $urandom_range(0, 100);
      step(($urandom_range(0, 99) < bias), 1'($urandom), 5'($urandom_range(0, 31)),
           $urandom, $urandom,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(LLD + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
